// File: rtl/viterbi_pkg.sv
// Shared Viterbi front-end definitions.
//   bm_width()  : branch-metric width that holds N_OUT * SMAX without overflow
//   soft_sym_t  : soft symbol for the default 3-bit soft-decision configuration
//   bm_t        : branch metric for the default rate-1/2, 3-bit configuration
package viterbi_pkg;

  localparam int SOFT_W_DEF = 3;
  localparam int N_OUT_DEF  = 2;

  function automatic int bm_width(input int n_out, input int soft_w);
    return $clog2(n_out * ((1 << soft_w) - 1) + 1);
  endfunction

  localparam int BM_W_DEF = bm_width(N_OUT_DEF, SOFT_W_DEF);

  typedef logic [SOFT_W_DEF-1:0] soft_sym_t;
  typedef logic [BM_W_DEF-1:0]   bm_t;

endpackage

// File: rtl/bmc_sym_dist.sv
// Per-symbol distance, combinational.
//   rx_i   : received soft symbol (0 = confident '0', all-ones = confident '1')
//   keep_i : symbol is present in this puncture phase
//   d0_o   : distance to an expected '0' (zero when erased)
//   d1_o   : distance to an expected '1' (zero when erased)
module bmc_sym_dist #(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] rx_i,
  input  logic              keep_i,
  output logic [SOFT_W-1:0] d0_o,
  output logic [SOFT_W-1:0] d1_o
);

  localparam logic [SOFT_W-1:0] SMAX = '1;

  assign d0_o = keep_i ? rx_i        : '0;
  assign d1_o = keep_i ? SMAX - rx_i : '0;

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage pipelined branch-metric unit.
//   clk, rst          : clock, async active-high reset
//   punct_pat         : static puncture pattern, bit p*N_OUT+j keeps symbol j in phase p
//   in_valid/in_ready : received symbol group handshake; in_sym, in_last ride with it
//   out_valid/out_ready: metric set handshake; out_bm, out_last, out_phase ride with it
// Stage 1 holds masked per-symbol distances, stage 2 holds the 2^N_OUT sums.
module bmc_soft_pipe
  import viterbi_pkg::*;
#(
  parameter  int N_OUT     = 2,
  parameter  int SOFT_W    = 3,
  parameter  int PUNCT_LEN = 4,
  localparam int MET_W     = bm_width(N_OUT, SOFT_W),
  localparam int NHYP      = 2 ** N_OUT,
  localparam int PH_W      = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PUNCT_LEN*N_OUT-1:0] punct_pat,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_OUT*SOFT_W-1:0]    in_sym,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NHYP*MET_W-1:0]      out_bm,
  output logic                       out_last,
  output logic [PH_W-1:0]            out_phase
);

  logic [2:1] vld_pipe_q;
  logic       s2_free, in_acc;

  // S2 can take new data when empty or being consumed; S1 follows S2.
  assign s2_free  = !vld_pipe_q[2] || out_ready;
  assign in_ready = !vld_pipe_q[1] || s2_free;
  assign in_acc   = in_valid && in_ready;

  // Puncture phase
  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (in_acc) begin
      if (in_last || int'(phase_q) == PUNCT_LEN - 1) phase_d = '0;
      else                                           phase_d = phase_q + 1'b1;
    end
  end

  logic [N_OUT-1:0] keep;
  assign keep = punct_pat[int'(phase_q)*N_OUT +: N_OUT];

  // Per-symbol distances
  logic [N_OUT-1:0][SOFT_W-1:0] sym, d0, d1;
  assign sym = in_sym;

  for (genvar j = 0; j < N_OUT; j++) begin : g_dist
    bmc_sym_dist #(.SOFT_W(SOFT_W)) u_dist (
      .rx_i  (sym[j]),
      .keep_i(keep[j]),
      .d0_o  (d0[j]),
      .d1_o  (d1[j])
    );
  end

  // Stage 1 registers
  logic [N_OUT-1:0][SOFT_W-1:0] s1_d0_q, s1_d1_q;
  logic                         s1_last_q;
  logic [PH_W-1:0]              s1_phase_q;

  // Hypothesis sums: bit j of h selects which polarity symbol j contributes.
  logic [NHYP-1:0][MET_W-1:0] bm_d;

  always_comb begin
    bm_d = '0;
    for (int h = 0; h < NHYP; h++) begin
      for (int j = 0; j < N_OUT; j++) begin
        bm_d[h] = bm_d[h] + MET_W'(h[j] ? s1_d1_q[j] : s1_d0_q[j]);
      end
    end
  end

  // Stage 2 registers
  logic [NHYP-1:0][MET_W-1:0] bm_q;
  logic                       s2_last_q;
  logic [PH_W-1:0]            s2_phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      phase_q    <= '0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
      s1_last_q  <= 1'b0;
      s1_phase_q <= '0;
      bm_q       <= '0;
      s2_last_q  <= 1'b0;
      s2_phase_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (in_ready) vld_pipe_q[1] <= in_valid;
      if (s2_free)  vld_pipe_q[2] <= vld_pipe_q[1];
      if (in_acc) begin
        s1_d0_q    <= d0;
        s1_d1_q    <= d1;
        s1_last_q  <= in_last;
        s1_phase_q <= phase_q;  // the group carrying last still reports its own phase
      end
      // Data only moves with a valid group so a stalled or idle S2 keeps its contents.
      if (s2_free && vld_pipe_q[1]) begin
        bm_q       <= bm_d;
        s2_last_q  <= s1_last_q;
        s2_phase_q <= s1_phase_q;
      end
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_bm    = bm_q;
  assign out_last  = s2_last_q;
  assign out_phase = s2_phase_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
module tb_bmc_soft_pipe;

  localparam int N_OUT = 2, SOFT_W = 3, PUNCT_LEN = 4;
  localparam int MET_W = 4, NHYP = 4, PH_W = 2, SMAX = 7;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [PUNCT_LEN*N_OUT-1:0] pat;
  logic                       in_valid, in_ready, in_last;
  logic [N_OUT*SOFT_W-1:0]    in_sym;
  logic                       out_valid, out_ready, out_last;
  logic [NHYP*MET_W-1:0]      out_bm;
  logic [PH_W-1:0]            out_phase;

  // hard-decision rate-1/2 instance, no puncturing
  logic [1:0] hd_pat = 2'b11;
  logic [1:0] hd_sym;
  logic       hd_in_valid, hd_in_ready, hd_out_valid, hd_out_last;
  logic       hd_in_last = 1'b0, hd_out_ready = 1'b1;
  logic [7:0] hd_out_bm;
  logic [0:0] hd_out_phase;

  always #5 clk = ~clk;

  bmc_soft_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .PUNCT_LEN(PUNCT_LEN)) dut (
    .clk(clk), .rst(rst), .punct_pat(pat),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bm(out_bm),
    .out_last(out_last), .out_phase(out_phase)
  );

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(1), .PUNCT_LEN(1)) u_hd (
    .clk(clk), .rst(rst), .punct_pat(hd_pat),
    .in_valid(hd_in_valid), .in_ready(hd_in_ready), .in_sym(hd_sym), .in_last(hd_in_last),
    .out_valid(hd_out_valid), .out_ready(hd_out_ready), .out_bm(hd_out_bm),
    .out_last(hd_out_last), .out_phase(hd_out_phase)
  );

  typedef struct {
    logic [NHYP*MET_W-1:0] bm;
    logic                  last;
    logic [PH_W-1:0]       ph;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   mphase = 0, n_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Metric of every hypothesis straight from the distance definition.
  function automatic logic [NHYP*MET_W-1:0] ref_bm(input logic [N_OUT*SOFT_W-1:0] sym,
                                                   input logic [PUNCT_LEN*N_OUT-1:0] p,
                                                   input int ph);
    logic [NHYP*MET_W-1:0] r;
    r = '0;
    for (int h = 0; h < NHYP; h++) begin
      int s;
      s = 0;
      for (int j = 0; j < N_OUT; j++) begin
        int rx;
        rx = int'(sym[j*SOFT_W +: SOFT_W]);
        if (p[ph*N_OUT + j]) s += ((h >> j) & 1) ? (SMAX - rx) : rx;
      end
      r[h*MET_W +: MET_W] = MET_W'(s);
    end
    return r;
  endfunction

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic cyc();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e.bm   = ref_bm(in_sym, pat, mphase);
      e.last = in_last;
      e.ph   = PH_W'(mphase);
      sb.push_back(e);
      mphase = in_last ? 0 : (mphase + 1) % PUNCT_LEN;
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_bm",    out_bm,    e.bm);
        chk("sb_last",  out_last,  e.last);
        chk("sb_phase", out_phase, e.ph);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   acc0;
    logic have;
    logic [NHYP*MET_W-1:0] held;

    rst = 1'b1; pat = '1; in_valid = 0; in_last = 0; in_sym = '0; out_ready = 1;
    hd_in_valid = 0; hd_sym = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bm",    out_bm,    0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_phase", out_phase, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // hard-decision Hamming metrics, sym0=1 sym1=0 -> {1,0,2,1}
    hd_sym = 2'b01; hd_in_valid = 1'b1;
    #1 chk("hd_in_ready", hd_in_ready, 1);
    @(posedge clk); @(negedge clk);
    hd_in_valid = 1'b0;
    chk("hd_lat1", hd_out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("hd_valid", hd_out_valid, 1);
    chk("hd_bm",    hd_out_bm, {2'd1, 2'd2, 2'd0, 2'd1});
    chk("hd_phase", hd_out_phase, 0);
    chk("hd_last",  hd_out_last, 0);

    // soft metrics and 2-cycle latency
    in_sym = {3'd0, 3'd7}; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lat1_valid", out_valid, 0);
    cyc();
    chk("lat2_valid", out_valid, 1);
    chk("bm_7_0", out_bm, {4'd7, 4'd14, 4'd0, 4'd7});
    in_sym = {3'd3, 3'd3}; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("bm_3_3", out_bm, {4'd8, 4'd7, 4'd7, 4'd6});
    drain();

    // puncturing: phase0 both kept, phase1 sym0 only, phases 2/3 fully erased
    pat = 8'b0000_0111; in_sym = {3'd7, 3'd7}; in_valid = 1'b1;
    repeat (4) cyc();
    drain();

    // backpressure: two groups fit, then in_ready drops and S2 holds
    pat = PUNCT_LEN*N_OUT'($urandom);
    out_ready = 1'b0; in_valid = 1'b1; acc0 = n_acc; have = 1'b0; held = '0;
    for (int i = 0; i < 5; i++) begin
      in_sym = N_OUT*SOFT_W'($urandom);
      cyc();
      if (out_valid) begin
        if (!have) begin held = out_bm; have = 1'b1; end
        else chk("bp_hold", out_bm, held);
      end
    end
    chk("bp_accepts", n_acc - acc0, 2);
    chk("bp_in_ready", in_ready, 0);
    drain();

    // frame boundary: last on the 3rd group (phase 2), next group restarts at 0
    in_valid = 1'b1; in_last = 1'b1; in_sym = N_OUT*SOFT_W'($urandom);
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2);
      in_sym  = N_OUT*SOFT_W'($urandom);
      cyc();
    end
    in_last = 1'b0;
    drain();

    // random traffic with random backpressure and frame ends
    pat = PUNCT_LEN*N_OUT'($urandom);
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_last   = ($urandom_range(0, 7) == 0);
      in_sym    = N_OUT*SOFT_W'($urandom);
      cyc();
    end
    in_last = 1'b0;
    drain();

    // async reset while both stages are full and stalled
    pat = '1; out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_bm",    out_bm,    0);
    chk("arst_last",  out_last,  0);
    chk("arst_phase", out_phase, 0);
    sb.delete(); mphase = 0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", out_valid, 0);
    end
    chk("post_rst_ready", in_ready, 1);
    in_valid = 1'b1; in_sym = N_OUT*SOFT_W'($urandom);
    cyc();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
